// File: rtl/gelato_warp_scheduler_pkg.sv
// ============================================================================
// gelato_types : shared types and widths for the gelato warp scheduler
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WARP_NUM
`define WARP_NUM 4
`endif

package gelato_types;
    localparam int INST_W    = 32;
    localparam int WARP_ID_W = $clog2(`WARP_NUM);

    typedef logic [INST_W-1:0] inst_t;
endpackage

`default_nettype wire

// File: rtl/gelato_warp_scheduler_rr_arbiter.sv
// ============================================================================
// gelato_rr_arbiter : rotating-priority search starting just above ptr
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gelato_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    int w_idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        w_idx = 0;
        // Offset N revisits ptr itself, so the last grantee is the lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!valid && req[w_idx[PTR_W-1:0]]) begin
                gnt[w_idx[PTR_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gelato_warp_scheduler.sv
// ============================================================================
// gelato_warp_scheduler : per-warp inflight-limited issue scheduler with a
// single registered issue slot. Optional macro GELATO_SKD_GREEDY_EN enables
// greedy re-grant of the last issued warp.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import gelato_types::*;

module gelato_warp_scheduler #(
    parameter int WARP_NUM     = `WARP_NUM,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic [WARP_NUM-1:0]           buf_valid,
    input  inst_t [WARP_NUM-1:0]          buf_inst,
    output logic [WARP_NUM-1:0]           buf_caught,
    input  logic [WARP_NUM-1:0]           warp_active,
    input  logic                          wb_valid,
    input  logic [WARP_ID_W-1:0]          wb_warp,
    output logic                          issue_valid,
    output inst_t                         issue_inst,
    output logic [WARP_ID_W-1:0]          issue_warp,
    input  logic                          issue_ready
);

    localparam int                CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0]  C_MAX   = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0]     r_inflight [WARP_NUM];
    logic [WARP_ID_W-1:0] r_ptr;

    logic [WARP_NUM-1:0]  w_eligible;
    logic [WARP_NUM-1:0]  w_rr_gnt;
    logic [WARP_NUM-1:0]  w_gnt;
    logic                 w_any;
    logic                 w_loadable;
    logic                 w_grant;
    logic [WARP_ID_W-1:0] w_grant_idx;
    logic [WARP_NUM-1:0]  w_inc;
    logic [WARP_NUM-1:0]  w_dec;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            w_eligible[i] = buf_valid[i] & warp_active[i] & (r_inflight[i] < C_MAX);
        end
    end

    gelato_rr_arbiter #(
        .N     (WARP_NUM),
        .PTR_W (WARP_ID_W)
    ) u_arb (
        .req   (w_eligible),
        .ptr   (r_ptr),
        .gnt   (w_rr_gnt),
        .valid (w_any)
    );

`ifdef GELATO_SKD_GREEDY_EN
    assign w_gnt = w_eligible[r_ptr] ? (WARP_NUM'(1) << r_ptr) : w_rr_gnt;
`else
    assign w_gnt = w_rr_gnt;
`endif

    assign w_loadable = rdy & (~issue_valid | issue_ready);
    assign w_grant    = w_loadable & w_any & ~rst;
    assign buf_caught = w_grant ? w_gnt : '0;

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            if (w_gnt[i]) begin
                w_grant_idx = WARP_ID_W'(i);
            end
        end
    end

    // Decrements are independent of rdy so a writeback is never dropped.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < WARP_NUM; i++) begin
            w_inc[i] = w_grant & w_gnt[i];
            w_dec[i] = wb_valid & (wb_warp == WARP_ID_W'(i)) & (r_inflight[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WARP_NUM; i++) begin
                r_inflight[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WARP_NUM; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_inflight[i] <= r_inflight[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_inflight[i] <= r_inflight[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_inst  <= '0;
            issue_warp  <= '0;
            r_ptr       <= WARP_ID_W'(WARP_NUM - 1);
        end else if (w_loadable) begin
            if (w_any) begin
                issue_valid <= 1'b1;
                issue_inst  <= buf_inst[w_grant_idx];
                issue_warp  <= w_grant_idx;
                r_ptr       <= w_grant_idx;
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/gelato_warp_scheduler.md
GELATO_WARP_SCHEDULER -- requirements
Module: gelato_warp_scheduler

Interface
REQ-001 SHALL have parameter WARP_NUM, default `WARP_NUM (4); number of warps served.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2; maximum un-written-back instructions per warp.
REQ-003 SHALL have the clock port: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have the reset port: rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have the port: rdy  in  1  global enable; low freezes issue state.
REQ-006 SHALL have the port: buf_valid  in  WARP_NUM  per-warp instruction-buffer head valid.
REQ-007 SHALL have the port: buf_inst  in  WARP_NUM x inst_t  per-warp instruction-buffer head instruction.
REQ-008 SHALL have the port: buf_caught  out  WARP_NUM  one-hot pop pulse back to the instruction buffer.
REQ-009 SHALL have the port: warp_active  in  WARP_NUM  warp enable mask.
REQ-010 SHALL have the port: wb_valid  in  1  writeback completion event.
REQ-011 SHALL have the port: wb_warp  in  WARP_ID_W  warp of the writeback event.
REQ-012 SHALL have the port: issue_valid  out  1  registered issue slot valid.
REQ-013 SHALL have the port: issue_inst  out  inst_t  issued instruction.
REQ-014 SHALL have the port: issue_warp  out  WARP_ID_W  issued warp index.
REQ-015 SHALL have the port: issue_ready  in  1  downstream accepts the issue slot.

Function
REQ-016 SHALL compute eligible[i] = buf_valid[i] & warp_active[i] & (inflight[i] < MAX_INFLIGHT).
REQ-017 SHALL treat the slot as loadable when rdy & (!issue_valid | issue_ready).
REQ-018 SHALL, when loadable and any warp eligible, grant the first eligible warp searching from (ptr+1) mod WARP_NUM upward, with wrap-around.
REQ-019 SHALL assert buf_caught[g] combinationally, in the same cycle as the grant, for exactly one cycle per grant; all other bits stay 0.
REQ-020 SHALL, on the edge following a grant, set issue_valid=1, issue_inst=buf_inst[g], issue_warp=g and ptr=g; issue latency is 1 cycle.
REQ-021 SHALL, when loadable with no eligible warp, clear issue_valid if it was accepted (issue_ready) and otherwise hold it.
REQ-022 SHALL hold issue_inst and issue_warp stable while issue_valid & !issue_ready.
REQ-023 SHALL support back-to-back issue: accept and grant in the same cycle gives one instruction per cycle.
REQ-024 SHALL increment inflight[g] on a grant and decrement inflight[wb_warp] on wb_valid.
REQ-025 SHALL leave a counter unchanged when it is incremented and decremented in the same cycle.
REQ-026 SHALL ignore wb_valid while inflight[wb_warp]==0, saturating the counter at 0.
REQ-027 SHALL size each counter as $clog2(MAX_INFLIGHT+1) bits.
REQ-028 SHALL, while rdy=0, make no grant, drive buf_caught=0 and hold ptr and the issue registers.
REQ-029 SHALL apply writeback decrements regardless of rdy, so that no event is lost.
REQ-030 SHALL let a warp deasserting warp_active finish its already-issued slot without taking new grants.

Reset
REQ-031 SHALL, while rst is high, force issue_valid=0, issue_inst=0, issue_warp=0, all inflight=0 and ptr=WARP_NUM-1, so that warp 0 has first priority.
REQ-032 SHALL, while rst is high, hold buf_caught=0.
REQ-033 SHALL, on reset mid-operation, discard the pending slot without replay.

Configuration
REQ-034 SHALL, with GELATO_SKD_GREEDY_EN defined, re-grant the last granted warp (ptr) when it is still eligible, falling back to round-robin otherwise.
REQ-035 SHALL, without GELATO_SKD_GREEDY_EN, use pure round-robin that never grants the same warp twice consecutively while another warp is eligible.

Structure
REQ-036 SHALL take inst_t, `WARP_NUM and WARP_ID_W = $clog2(WARP_NUM) from package gelato_types.
REQ-037 SHALL place the rotating priority search in one sub-module, gelato_rr_arbiter (request vector, pointer in; one-hot grant and valid out).
REQ-038 SHALL keep the inflight counters, issue register and greedy logic in the top module.

Verification (WARP_NUM=4, MAX_INFLIGHT=2)
REQ-039 SHALL cover: reset release, buf_valid=4'b1111, issue_ready=1 -> caught order 0,1,2,3,0; issue_warp follows 1 cycle later.
REQ-040 SHALL cover: only warp 2 valid, no writeback -> two grants, then inflight[2]=2 blocks it; wb_valid with wb_warp=2 -> third grant next cycle.
REQ-041 SHALL cover: issue_ready=0 for 3 cycles with a slot held -> buf_caught=0 and issue_inst stable; ready=1 -> next grant same cycle.
REQ-042 SHALL cover: grant to warp 1 and wb_valid with wb_warp=1 in the same cycle at inflight=1 -> inflight[1] stays 1; wb to an idle warp -> counter stays 0.
REQ-043 SHALL cover: GELATO_SKD_GREEDY_EN defined, warps 0 and 1 always valid, wb every cycle -> warp 0 granted continuously; undefined -> 0,1 alternating.
REQ-044 SHALL cover: rst asserted while issue_valid=1 -> issue_valid=0 immediately (asynchronously); after release, the first grant goes to warp 0.
